delay_line_ctrl: RTL
====================

# delay_line_ctrl

Multi-channel controller for the mux-tree programmable clock delay lines in the memory-controller clocking path. It owns the delay-select codes of `NumChan` delay lines and accepts per-channel code writes over a valid/ready port. It applies new codes under a settle-time guard, optionally slewing one code step at a time. It also runs a per-channel calibration sweep that finds the smallest code at which an external phase detector reports "late".

## Interface
- `NumChan`, 4: number of delay lines controlled (≥1).
- `DelayWidth`, 4: code width per line; codes span 0..2^DelayWidth−1.
- `SettleCycles`, 4: cycles a code is held before the next action (≥3; covers the 2-flop phase synchroniser).
- `ResetCode`, 0: code loaded into every channel on reset.
- `ChanWidth`, derived: max(1, $clog2(NumChan)).

- `clk_i` in 1: clock. Single clock domain.
- `rst_i` in 1: reset. Synchronous and active-high.
- `cfg_valid_i` in 1: request valid.
- `cfg_ready_o` out 1: controller idle, request can be accepted.
- `cfg_chan_i` in ChanWidth: target channel.
- `cfg_delay_i` in DelayWidth: target code; ignored when `cfg_cal_i`=1.
- `cfg_cal_i` in 1: 1 = run calibration on `cfg_chan_i`.
- `phase_i` in NumChan: asynchronous phase-detector outputs, 1 = late. Each bit is synchronised internally with 2 flops.
- `delay_o` out NumChan*DelayWidth: channel c code on bits [c*DelayWidth +: DelayWidth].
- `busy_o` out 1: equals !`cfg_ready_o`.
- `cal_done_o` out 1: one-cycle pulse when a calibration ends.
- `cal_fail_o` out 1: valid with `cal_done_o`; 1 = no code produced "late".
- `cal_code_o` out DelayWidth: last calibration result. Holds its value until the next calibration ends.

## Operation
- FSM states are IDLE, APPLY, SETTLE, CAL_SET, CAL_WAIT and CAL_END.
- IDLE: `cfg_ready_o`=1. A handshake occurs on `cfg_valid_i`&&`cfg_ready_o`, and `cfg_chan_i`/`cfg_delay_i` are latched at that edge.
- Channel index ≥ NumChan: the request is accepted and no other action is taken; the FSM stays in IDLE.
- Write with target equal to the current code: no effect, FSM stays in IDLE, `cfg_ready_o` stays 1.
- APPLY: loads the next code into the channel, then goes to SETTLE. SETTLE counts SettleCycles, then either returns to APPLY (more steps remain) or goes to IDLE.
- Only the addressed channel's code ever changes; all other channels hold their codes.
- CAL_SET:
  - Saves the channel's original code.
  - Loads code 0 directly; calibration never slews.
  - Goes to CAL_WAIT.
- CAL_WAIT:
  - After SettleCycles, samples the synchronised `phase_i[chan]`.
  - If 1: result = current code, go to CAL_END with fail=0.
  - Else if code = max: restore the original code, go to CAL_END with fail=1.
  - Else: increment the code and wait again.
- CAL_END: pulses `cal_done_o`, updates `cal_code_o` and `cal_fail_o`, then returns to IDLE.
- Codes never wrap: they stay within 0..max at all times.

## Timing
- Reset values:
  - every `delay_o` lane = ResetCode;
  - `cfg_ready_o`=1, `busy_o`=0;
  - `cal_done_o`=0, `cal_fail_o`=0, `cal_code_o`=0;
  - FSM in IDLE, synchronisers cleared.
- Handshake at edge k: `cfg_ready_o` falls after edge k.
- First new code on `delay_o`: visible after edge k+1.
- A write of Δ steps (macro off, Δ treated as 1) returns `cfg_ready_o` high after edge k+1+Δ·SettleCycles.
- Calibration reaching code n (n+1 codes tried): the `cal_done_o` pulse occurs in cycle k+2+(n+1)·SettleCycles. `cfg_ready_o` is 1 in the following cycle.
- The same cycle timing applies when calibration fails at code max.
- Reset asserted mid-operation: the FSM is aborted and all reset values apply at the next edge, with no restore of the original code.
- Outputs are registered. `cal_code_o` and `cal_fail_o` change only in the CAL_END cycle.

## Configuration
- `DELAY_CTRL_SLEW_EN` defined: APPLY moves the code by ±1 toward the target, and each step is held for SettleCycles. This limits the phase jump per update.
- `DELAY_CTRL_SLEW_EN` undefined: APPLY loads the target code in one step, followed by a single SettleCycles hold.
- Calibration behaviour is identical in both builds.

## Test plan
All scenarios use defaults NumChan=4, DelayWidth=4, SettleCycles=4, ResetCode=0.
- Reset: hold `rst_i` for 2 cycles → `delay_o`=16'h0000, `cfg_ready_o`=1, `cal_done_o`=0.
- Write ch2 code 5, slew off → `delay_o`=16'h0500 after edge k+1; `cfg_ready_o` low for 5 cycles.
- Write ch2 code 5, slew on → ch2 takes 1,2,3,4,5, each held 4 cycles; `cfg_ready_o` high after edge k+21.
- Calibration pass:
  - Setup: ch1 preset to code 3; `phase_i[1]`=1 whenever ch1 code ≥9.
  - Expected: `cal_done_o` pulse with `cal_fail_o`=0 and `cal_code_o`=9; ch1 stays at 9.
- Calibration fail: same ch1 preset with `phase_i`=0 throughout → code reaches 15, `cal_fail_o`=1, ch1 is restored to 3.
- Edge cases:
  - Write to chan 3 with `cfg_chan_i`=3 but NumChan=3 build → accepted, `delay_o` unchanged, `cfg_ready_o` stays 1.
  - `rst_i` pulsed mid-slew from 0→12 → all lanes = 0 on the next edge, FSM in IDLE.

Source files
------------

// File: rtl/delay_line_ctrl.sv
// Multi-channel controller for mux-tree clock delay lines: settle-guarded code updates and a phase-detector calibration sweep.
// Build option: define DELAY_CTRL_SLEW_EN to move codes one LSB per settle window instead of jumping to the target.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a request
// APPLY    | load the next code (target, or one step toward it)
// SETTLE   | hold the code for the settle window
// CAL_SET  | save the original code, load code 0
// CAL_WAIT | settle, then sample the synchronised phase detector
// CAL_END  | report the calibration result for one cycle

module delay_line_ctrl #(
    parameter int NumChan      = 4,
    parameter int DelayWidth   = 4,
    parameter int SettleCycles = 4,
    parameter int ResetCode    = 0,
    parameter int ChanWidth    = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [ChanWidth-1:0]            cfg_chan_i,
    input  logic [DelayWidth-1:0]           cfg_delay_i,
    input  logic                            cfg_cal_i,
    input  logic [NumChan-1:0]              phase_i,
    output logic [NumChan*DelayWidth-1:0]   delay_o,
    output logic                            busy_o,
    output logic                            cal_done_o,
    output logic                            cal_fail_o,
    output logic [DelayWidth-1:0]           cal_code_o
);

    localparam int TimerWidth = (SettleCycles > 2) ? $clog2(SettleCycles) : 1;
    localparam logic [TimerWidth-1:0] SettleLong  = TimerWidth'(SettleCycles - 1);
    localparam logic [TimerWidth-1:0] SettleShort = TimerWidth'(SettleCycles - 2);
    localparam logic [DelayWidth-1:0] CodeMax     = {DelayWidth{1'b1}};
    localparam logic [DelayWidth-1:0] CodeOne     = DelayWidth'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        APPLY    = 3'd1,
        SETTLE   = 3'd2,
        CAL_SET  = 3'd3,
        CAL_WAIT = 3'd4,
        CAL_END  = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [DelayWidth-1:0]  codes [NumChan];
    logic [ChanWidth-1:0]   chan;
    logic [DelayWidth-1:0]  target;
    logic [DelayWidth-1:0]  orig;
    logic [TimerWidth-1:0]  timer;
    logic [NumChan-1:0]     sync_a;
    logic [NumChan-1:0]     sync_b;
    logic                   cal_done;
    logic                   cal_fail;
    logic [DelayWidth-1:0]  cal_code;

    logic [DelayWidth-1:0]  cur_code;
    logic [DelayWidth-1:0]  req_code;
    logic [DelayWidth-1:0]  step_code;
    logic                   phase_sel;
    logic                   req_chan_ok;
    logic                   timer_done;

    logic                   code_we;
    logic [DelayWidth-1:0]  code_wd;
    logic                   timer_ld;
    logic [TimerWidth-1:0]  timer_wd;
    logic                   req_take;
    logic                   orig_save;
    logic                   done_set;
    logic                   fail_set;

    // Channel read muxes: latched channel for the datapath, request channel for the no-op check
    always_comb begin
        cur_code  = '0;
        req_code  = '0;
        phase_sel = 1'b0;
        for (int c = 0; c < NumChan; c++) begin
            if (chan == ChanWidth'(c)) begin
                cur_code  = codes[c];
                phase_sel = sync_b[c];
            end
            if (cfg_chan_i == ChanWidth'(c)) begin
                req_code = codes[c];
            end
        end
    end

    generate
        if (NumChan == (1 << ChanWidth)) begin : g_chan_full
            assign req_chan_ok = 1'b1;
        end else begin : g_chan_part
            assign req_chan_ok = (cfg_chan_i < ChanWidth'(NumChan));
        end
    endgenerate

`ifdef DELAY_CTRL_SLEW_EN
    assign step_code = (target > cur_code) ? (cur_code + CodeOne) : (cur_code - CodeOne);
`else
    assign step_code = target;
`endif

    assign timer_done = (timer == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_we   = 1'b0;
        code_wd   = cur_code;
        timer_ld  = 1'b0;
        timer_wd  = SettleLong;
        req_take  = 1'b0;
        orig_save = 1'b0;
        done_set  = 1'b0;
        fail_set  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid_i) begin
                    req_take = 1'b1;
                    if (req_chan_ok) begin
                        if (cfg_cal_i) begin
                            state_nxt = CAL_SET;
                        end else if (req_code != cfg_delay_i) begin
                            state_nxt = APPLY;
                        end
                    end
                end
            end
            APPLY: begin
                code_we   = 1'b1;
                code_wd   = step_code;
                timer_ld  = 1'b1;
                // Intermediate slew steps count the APPLY cycle as part of their hold
                timer_wd  = (step_code == target) ? SettleLong : SettleShort;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (timer_done) begin
                    state_nxt = (cur_code == target) ? IDLE : APPLY;
                end
            end
            CAL_SET: begin
                orig_save = 1'b1;
                code_we   = 1'b1;
                code_wd   = '0;
                timer_ld  = 1'b1;
                state_nxt = CAL_WAIT;
            end
            CAL_WAIT: begin
                if (timer_done) begin
                    if (phase_sel) begin
                        done_set  = 1'b1;
                        state_nxt = CAL_END;
                    end else if (cur_code == CodeMax) begin
                        done_set  = 1'b1;
                        fail_set  = 1'b1;
                        code_we   = 1'b1;
                        code_wd   = orig;
                        state_nxt = CAL_END;
                    end else begin
                        code_we  = 1'b1;
                        code_wd  = cur_code + CodeOne;
                        timer_ld = 1'b1;
                    end
                end
            end
            CAL_END: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumChan; c++) begin
                codes[c] <= DelayWidth'(ResetCode);
            end
            chan     <= '0;
            target   <= '0;
            orig     <= '0;
            timer    <= '0;
            sync_a   <= '0;
            sync_b   <= '0;
            cal_done <= 1'b0;
            cal_fail <= 1'b0;
            cal_code <= '0;
        end else begin
            sync_a <= phase_i;
            sync_b <= sync_a;
            if (req_take) begin
                chan   <= cfg_chan_i;
                target <= cfg_delay_i;
            end
            if (orig_save) begin
                orig <= cur_code;
            end
            for (int c = 0; c < NumChan; c++) begin
                if (code_we && (chan == ChanWidth'(c))) begin
                    codes[c] <= code_wd;
                end
            end
            if (timer_ld) begin
                timer <= timer_wd;
            end else if (!timer_done) begin
                timer <= timer - TimerWidth'(1);
            end
            cal_done <= done_set;
            if (done_set) begin
                cal_fail <= fail_set;
                cal_code <= cur_code;
            end
        end
    end

    generate
        for (genvar g = 0; g < NumChan; g++) begin : g_lane
            assign delay_o[g*DelayWidth +: DelayWidth] = codes[g];
        end
    endgenerate

    assign cfg_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign cal_done_o  = cal_done;
    assign cal_fail_o  = cal_fail;
    assign cal_code_o  = cal_code;

endmodule
